pim_dma_q: RTL and testbench

Queued, parametrised DMA engine moving 32-bit words between on-chip SRAM and N_PIM processing-in-memory macros. It sits between the core's PIM custom-instruction decode and the shared system bus, on both the SRAM port (port 0) and the PIM port (port 1). Compared with the single-shot PIM DMA, it adds:
- a command FIFO, so back-to-back instructions do not stall the core;
- a configurable SRAM address stride;
- a 2-entry data buffer that sustains 1 word/cycle across grant drops;
- an abort input and error reporting.

---
 rtl/pim_dma_q.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_pim_dma_q.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pim_dma_q.sv
// pim_dma_q: queued DMA engine that moves 32-bit words between on-chip SRAM
// (port 0) and the processing-in-memory macro window (port 1).
//
// Ports
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o   command handshake into the command FIFO
//   cmd_funct3_i              opcode (001/010/101/110/111 SRAM->PIM, 100 PIM->SRAM)
//   cmd_sel_i                 target macro index
//   cmd_size_i                transfer length in words
//   cmd_addr_i                SRAM byte start address
//   cmd_stride_i              SRAM increment in words (0 = fixed address)
//   abort_i                   flush FSM, FIFO and data buffer
//   bus_req_o/bus_gnt_i       shared bus arbitration
//   dma_*_0_*                 SRAM port (addr, write, read, size, wr_data, rd_data)
//   dma_*_1_*                 PIM port (same set)
//   busy_o                    engine active or commands queued
//   done_o                    one-cycle pulse per completed command
//   err_o                     one-cycle pulse per illegal command
//   level_o                   command FIFO occupancy
module pim_dma_q #(
    parameter logic [31:0] PIM_BASE  = 32'h4000_0000,
    parameter int unsigned N_PIM     = 4,
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned CNT_W     = 13,
    localparam int unsigned SEL_W    = (N_PIM > 1) ? $clog2(N_PIM) : 1,
    localparam int unsigned LVL_W    = $clog2(CMD_DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_funct3_i,
    input  logic [SEL_W-1:0] cmd_sel_i,
    input  logic [CNT_W-1:0] cmd_size_i,
    input  logic [31:0]      cmd_addr_i,
    input  logic [7:0]       cmd_stride_i,
    input  logic             abort_i,
    output logic             bus_req_o,
    input  logic             bus_gnt_i,
    output logic [31:0]      dma_addr_0_o,
    output logic             dma_write_0_o,
    output logic             dma_read_0_o,
    output logic [3:0]       dma_size_0_o,
    output logic [31:0]      dma_wr_data_0_o,
    input  logic [31:0]      dma_rd_data_0_i,
    output logic [31:0]      dma_addr_1_o,
    output logic             dma_write_1_o,
    output logic             dma_read_1_o,
    output logic [3:0]       dma_size_1_o,
    output logic [31:0]      dma_wr_data_1_o,
    input  logic [31:0]      dma_rd_data_1_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [LVL_W-1:0] level_o
);

    localparam int unsigned PTR_W = $clog2(CMD_DEPTH);
    localparam logic [31:0] CTRL_ADDR = PIM_BASE + 32'h0000_0010;
    localparam logic [31:0] READ_ADDR = PIM_BASE + 32'h0000_0020;

    typedef enum logic [1:0] {IDLE, POLL, STREAM} state_t;

    typedef struct packed {
        logic [2:0]       funct3;
        logic [SEL_W-1:0] sel;
        logic [CNT_W-1:0] size;
        logic [31:0]      addr;
        logic [7:0]       stride;
    } cmd_t;

    // Command FIFO
    cmd_t             fifo_q [CMD_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    cmd_t             head;
    logic             push, pop, head_legal;

    // Working registers
    state_t           state_q;
    logic [2:0]       funct3_q;
    logic [SEL_W-1:0] sel_q;
    logic [CNT_W-1:0] rd_left_q, wr_left_q;
    logic [31:0]      sram_addr_q;
    logic [7:0]       stride_q;
    logic             poll_pend_q;
    logic             inflight_q;
    logic             done_q, err_q;

    // 2-entry data buffer
    logic [31:0]      buf_q [2];
    logic             buf_wr_q, buf_rd_q;
    logic [1:0]       occ_q;

    logic             is_load, ctrl_ready;
    logic             poll_rd, st_rd, st_wr, sram_acc;
    logic [2:0]       pending;
    logic [31:0]      op_off, pim_op_addr, pim_rd_addr, src_data, sram_step;

    assign head        = fifo_q[rd_ptr_q];
    assign head_legal  = (head.funct3 != 3'b000) && (head.funct3 != 3'b011);
    assign cmd_ready_o = (level_q < LVL_W'(CMD_DEPTH));
    assign push        = cmd_valid_i & cmd_ready_o & ~abort_i;
    assign pop         = (state_q == IDLE) & (level_q != '0) & ~abort_i;

    assign is_load    = (funct3_q == 3'b100);
    assign ctrl_ready = is_load ? (dma_rd_data_1_i[0] & dma_rd_data_1_i[1])
                                : dma_rd_data_1_i[0];

    always_comb begin
        op_off = '0;
        case (funct3_q)
            3'b001:  op_off = 32'h0000_0040;
            3'b010:  op_off = 32'h0000_0080;
            3'b101:  op_off = 32'h0000_0100;
            3'b110:  op_off = 32'h0000_0200;
            3'b111:  op_off = 32'h0000_0400;
            default: op_off = '0;
        endcase
    end

    assign pim_op_addr = (PIM_BASE + op_off) | 32'(sel_q);
    assign pim_rd_addr = READ_ADDR | 32'(sel_q);
    assign src_data    = is_load ? dma_rd_data_1_i : dma_rd_data_0_i;
    assign sram_step   = {22'd0, stride_q, 2'b00};

    // A read may issue only if the data it returns will find a free buffer
    // slot, counting the word already in flight and the one leaving now.
    assign poll_rd  = (state_q == POLL) & bus_gnt_i;
    assign st_wr    = (state_q == STREAM) & bus_gnt_i & (occ_q != 2'd0);
    assign pending  = 3'(occ_q) + 3'(inflight_q) - 3'(st_wr);
    assign st_rd    = (state_q == STREAM) & bus_gnt_i & (rd_left_q != '0) & (pending < 3'd2);
    assign sram_acc = is_load ? st_wr : st_rd;

    always_comb begin
        dma_addr_0_o    = '0;
        dma_write_0_o   = 1'b0;
        dma_read_0_o    = 1'b0;
        dma_size_0_o    = '0;
        dma_wr_data_0_o = '0;
        dma_addr_1_o    = '0;
        dma_write_1_o   = 1'b0;
        dma_read_1_o    = 1'b0;
        dma_size_1_o    = '0;
        dma_wr_data_1_o = '0;
        if (poll_rd) begin
            dma_addr_1_o = CTRL_ADDR;
            dma_read_1_o = 1'b1;
            dma_size_1_o = '1;
        end
        if (st_rd) begin
            if (is_load) begin
                dma_addr_1_o = pim_rd_addr;
                dma_read_1_o = 1'b1;
                dma_size_1_o = '1;
            end else begin
                dma_addr_0_o = sram_addr_q;
                dma_read_0_o = 1'b1;
                dma_size_0_o = '1;
            end
        end
        if (st_wr) begin
            if (is_load) begin
                dma_addr_0_o    = sram_addr_q;
                dma_write_0_o   = 1'b1;
                dma_size_0_o    = '1;
                dma_wr_data_0_o = buf_q[buf_rd_q];
            end else begin
                dma_addr_1_o    = pim_op_addr;
                dma_write_1_o   = 1'b1;
                dma_size_1_o    = '1;
                dma_wr_data_1_o = buf_q[buf_rd_q];
            end
        end
    end

    assign bus_req_o = (state_q != IDLE);
    assign busy_o    = (state_q != IDLE) | (level_q != '0);
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign level_o   = level_q;

    // Storage arrays carry no reset; validity is tracked by pointers/levels.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{funct3: cmd_funct3_i, sel: cmd_sel_i, size: cmd_size_i,
                                  addr: cmd_addr_i, stride: cmd_stride_i};
        end
        if ((state_q == STREAM) && inflight_q && !abort_i) begin
            buf_q[buf_wr_q] <= src_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            funct3_q    <= '0;
            sel_q       <= '0;
            rd_left_q   <= '0;
            wr_left_q   <= '0;
            sram_addr_q <= '0;
            stride_q    <= '0;
            poll_pend_q <= 1'b0;
            inflight_q  <= 1'b0;
            buf_wr_q    <= 1'b0;
            buf_rd_q    <= 1'b0;
            occ_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (abort_i) begin
                state_q     <= IDLE;
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                level_q     <= '0;
                rd_left_q   <= '0;
                wr_left_q   <= '0;
                poll_pend_q <= 1'b0;
                inflight_q  <= 1'b0;
                buf_wr_q    <= 1'b0;
                buf_rd_q    <= 1'b0;
                occ_q       <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                level_q <= level_q + LVL_W'(push) - LVL_W'(pop);

                case (state_q)
                    IDLE: begin
                        if (pop) begin
                            if (!head_legal) begin
                                err_q <= 1'b1;
                            end else if (head.size == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                funct3_q    <= head.funct3;
                                sel_q       <= head.sel;
                                rd_left_q   <= head.size;
                                wr_left_q   <= head.size;
                                sram_addr_q <= head.addr;
                                stride_q    <= head.stride;
                                poll_pend_q <= 1'b0;
                                state_q     <= POLL;
                            end
                        end
                    end
                    POLL: begin
                        poll_pend_q <= poll_rd;
                        if (poll_pend_q && ctrl_ready) begin
                            poll_pend_q <= 1'b0;
                            inflight_q  <= 1'b0;
                            buf_wr_q    <= 1'b0;
                            buf_rd_q    <= 1'b0;
                            occ_q       <= '0;
                            state_q     <= STREAM;
                        end
                    end
                    STREAM: begin
                        inflight_q <= st_rd;
                        if (st_rd) rd_left_q <= rd_left_q - CNT_W'(1);
                        if (st_wr) begin
                            wr_left_q <= wr_left_q - CNT_W'(1);
                            buf_rd_q  <= ~buf_rd_q;
                        end
                        if (inflight_q) buf_wr_q <= ~buf_wr_q;
                        occ_q <= occ_q + 2'(inflight_q) - 2'(st_wr);
                        if (sram_acc) sram_addr_q <= sram_addr_q + sram_step;
                        if (st_wr && (wr_left_q == CNT_W'(1))) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pim_dma_q.sv
module tb_pim_dma_q;

    localparam logic [31:0] CTRL_A = 32'h4000_0010;
    localparam int K_PIM  = 0;
    localparam int K_SRAM = 1;
    localparam int K_DONE = 2;
    localparam int K_ERR  = 3;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [2:0]  cmd_funct3_i = '0;
    logic [1:0]  cmd_sel_i = '0;
    logic [12:0] cmd_size_i = '0;
    logic [31:0] cmd_addr_i = '0;
    logic [7:0]  cmd_stride_i = '0;
    logic        abort_i = 1'b0;
    logic        bus_req_o;
    logic        bus_gnt_i;
    logic [31:0] dma_addr_0_o, dma_wr_data_0_o, dma_rd_data_0_i;
    logic        dma_write_0_o, dma_read_0_o;
    logic [3:0]  dma_size_0_o;
    logic [31:0] dma_addr_1_o, dma_wr_data_1_o, dma_rd_data_1_i;
    logic        dma_write_1_o, dma_read_1_o;
    logic [3:0]  dma_size_1_o;
    logic        busy_o, done_o, err_o;
    logic [2:0]  level_o;

    int vectors = 0;
    int miscompares = 0;
    ev_t exp_q[$];

    // bench-side models
    logic        gnt_hold = 1'b0;
    logic        gnt_toggle = 1'b0;
    logic        tog_val = 1'b0;
    int          tcnt = 0;
    int          poll_delay = 0;
    logic [31:0] ctrl_ready_val = 32'h1;
    logic        tb_clear = 1'b0;
    int          poll_cnt = 0;
    int          pim_seq = 0;
    logic        bit1_returned = 1'b0;
    int          wr1_cnt = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;

    assign bus_gnt_i = gnt_toggle ? tog_val : gnt_hold;

    pim_dma_q dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_funct3_i(cmd_funct3_i), .cmd_sel_i(cmd_sel_i),
        .cmd_size_i(cmd_size_i), .cmd_addr_i(cmd_addr_i),
        .cmd_stride_i(cmd_stride_i), .abort_i(abort_i),
        .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i),
        .dma_addr_0_o(dma_addr_0_o), .dma_write_0_o(dma_write_0_o),
        .dma_read_0_o(dma_read_0_o), .dma_size_0_o(dma_size_0_o),
        .dma_wr_data_0_o(dma_wr_data_0_o), .dma_rd_data_0_i(dma_rd_data_0_i),
        .dma_addr_1_o(dma_addr_1_o), .dma_write_1_o(dma_write_1_o),
        .dma_read_1_o(dma_read_1_o), .dma_size_1_o(dma_size_1_o),
        .dma_wr_data_1_o(dma_wr_data_1_o), .dma_rd_data_1_i(dma_rd_data_1_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .level_o(level_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] sram_fn(input logic [31:0] a);
        return 32'hA500_0000 | a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // grant pattern 1,0,0,1,0,0,...
    always @(posedge clk_i) begin
        #1;
        tog_val = (tcnt % 3 == 0);
        tcnt++;
    end

    // SRAM / PIM responders with one-cycle read latency
    always @(posedge clk_i) begin
        if (tb_clear) begin
            poll_cnt      = 0;
            pim_seq       = 0;
            bit1_returned = 1'b0;
        end else begin
            if (dma_read_0_o) dma_rd_data_0_i <= sram_fn(dma_addr_0_o);
            if (dma_read_1_o) begin
                if (dma_addr_1_o == CTRL_A) begin
                    if (poll_cnt < poll_delay) begin
                        dma_rd_data_1_i <= 32'h1;
                    end else begin
                        dma_rd_data_1_i <= ctrl_ready_val;
                        if (ctrl_ready_val[1]) bit1_returned = 1'b1;
                    end
                    poll_cnt++;
                end else begin
                    dma_rd_data_1_i <= 32'hC0DE_0000 + 32'(pim_seq);
                    pim_seq++;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an output event
    always @(negedge clk_i) begin
        ev_t e;
        if (rst_ni) begin
            if (dma_write_1_o) begin
                wr1_cnt++;
                if (exp_q.size() == 0) check("unexp_pim_wr", 32'(dma_write_1_o), 32'h0);
                else begin
                    e = exp_q.pop_front();
                    check("pim_wr_kind", K_PIM, e.kind);
                    check("pim_wr_addr", dma_addr_1_o, e.addr);
                    check("pim_wr_data", dma_wr_data_1_o, e.data);
                    check("pim_wr_size", 32'(dma_size_1_o), 32'hF);
                end
            end
            if (dma_write_0_o) begin
                check("sram_wr_before_bit1", 32'(bit1_returned), 32'h1);
                if (exp_q.size() == 0) check("unexp_sram_wr", 32'(dma_write_0_o), 32'h0);
                else begin
                    e = exp_q.pop_front();
                    check("sram_wr_kind", K_SRAM, e.kind);
                    check("sram_wr_addr", dma_addr_0_o, e.addr);
                    check("sram_wr_data", dma_wr_data_0_o, e.data);
                end
            end
            if (done_o) begin
                done_cnt++;
                if (exp_q.size() == 0) check("unexp_done", 32'(done_o), 32'h0);
                else begin
                    e = exp_q.pop_front();
                    check("done_order", K_DONE, e.kind);
                end
            end
            if (err_o) begin
                err_cnt++;
                if (exp_q.size() == 0) check("unexp_err", 32'(err_o), 32'h0);
                else begin
                    e = exp_q.pop_front();
                    check("err_order", K_ERR, e.kind);
                end
            end
            if (!bus_gnt_i && bus_req_o)
                check("strobe_without_gnt",
                      {28'd0, dma_read_0_o, dma_write_0_o, dma_read_1_o, dma_write_1_o}, 32'h0);
        end
    end

    task automatic clear_models();
        tb_clear = 1'b1;
        tick(1);
        tb_clear = 1'b0;
    endtask

    task automatic expect_cmd(input logic [2:0] f, input int size, input logic [31:0] addr,
                              input int stride, input logic [31:0] pim_a);
        ev_t e;
        logic [31:0] a;
        if (f == 3'b000 || f == 3'b011) begin
            e = '{K_ERR, 32'h0, 32'h0};
            exp_q.push_back(e);
        end else if (size == 0) begin
            e = '{K_DONE, 32'h0, 32'h0};
            exp_q.push_back(e);
        end else begin
            for (int i = 0; i < size; i++) begin
                a = addr + 32'(i * stride * 4);
                if (f == 3'b100) e = '{K_SRAM, a, 32'hC0DE_0000 + 32'(i)};
                else             e = '{K_PIM, pim_a, sram_fn(a)};
                exp_q.push_back(e);
            end
            e = '{K_DONE, 32'h0, 32'h0};
            exp_q.push_back(e);
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic [1:0] sel, input logic [12:0] size,
                         input logic [31:0] addr, input logic [7:0] stride);
        int w;
        w = 0;
        while (!cmd_ready_o && w < 500) begin
            tick(1);
            w++;
        end
        if (!cmd_ready_o) check("cmd_ready_timeout", 32'(cmd_ready_o), 32'h1);
        cmd_valid_i  = 1'b1;
        cmd_funct3_i = f;
        cmd_sel_i    = sel;
        cmd_size_i   = size;
        cmd_addr_i   = addr;
        cmd_stride_i = stride;
        tick(1);
        cmd_valid_i  = 1'b0;
    endtask

    task automatic drain(input string name, input int max_cycles);
        int w;
        w = 0;
        while ((exp_q.size() != 0 || busy_o) && w < max_cycles) begin
            tick(1);
            w++;
        end
        check({name, "_pending_events"}, 32'(exp_q.size()), 32'h0);
        check({name, "_busy"}, 32'(busy_o), 32'h0);
    endtask

    initial begin
        int d0, e0, w, base, quiet;
        dma_rd_data_0_i = '0;
        dma_rd_data_1_i = '0;
        #1;
        check("rst_ready", 32'(cmd_ready_o), 32'h1);
        check("rst_ctl", {25'd0, bus_req_o, busy_o, done_o, err_o, level_o}, 32'h0);
        check("rst_p0", {dma_addr_0_o | dma_wr_data_0_o}
                        | {27'd0, dma_write_0_o, dma_size_0_o} | {31'd0, dma_read_0_o}, 32'h0);
        check("rst_p1", {dma_addr_1_o | dma_wr_data_1_o}
                        | {27'd0, dma_write_1_o, dma_size_1_o} | {31'd0, dma_read_1_o}, 32'h0);
        tick(2);
        rst_ni = 1'b1;
        tick(1);

        // weight op, grant held, ctrl ready at once
        gnt_hold = 1'b1;
        ctrl_ready_val = 32'h1;
        poll_delay = 0;
        clear_models();
        d0 = done_cnt;
        expect_cmd(3'b001, 4, 32'h100, 1, 32'h4000_0042);
        issue(3'b001, 2'd2, 13'd4, 32'h100, 8'd1);
        @(negedge clk_i);
        check("poll_not_before_pop", 32'(dma_read_1_o), 32'h0);
        @(negedge clk_i);
        check("first_poll_read", 32'(dma_read_1_o), 32'h1);
        check("first_poll_addr", dma_addr_1_o, CTRL_A);
        tick(1);
        drain("weight", 200);
        check("weight_done_count", 32'(done_cnt - d0), 32'h1);

        // load op, bit1 withheld for five polls
        ctrl_ready_val = 32'h3;
        poll_delay = 5;
        clear_models();
        d0 = done_cnt;
        expect_cmd(3'b100, 3, 32'h400, 2, 32'h0);
        issue(3'b100, 2'd1, 13'd3, 32'h400, 8'd2);
        drain("load", 200);
        check("load_done_count", 32'(done_cnt - d0), 32'h1);
        check("load_polls_seen", 32'(poll_cnt > 5), 32'h1);

        // activation op under toggling grant, with four commands queued behind it
        ctrl_ready_val = 32'h1;
        poll_delay = 0;
        clear_models();
        d0 = done_cnt;
        e0 = err_cnt;
        gnt_toggle = 1'b1;
        expect_cmd(3'b010, 16, 32'h800, 1, 32'h4000_0080);
        issue(3'b010, 2'd0, 13'd16, 32'h800, 8'd1);
        tick(10);
        expect_cmd(3'b001, 2, 32'h200, 0, 32'h4000_0041);
        expect_cmd(3'b110, 0, 32'h0, 0, 32'h0);
        expect_cmd(3'b011, 5, 32'h0, 0, 32'h0);
        expect_cmd(3'b101, 3, 32'h300, 3, 32'h4000_0103);
        issue(3'b001, 2'd1, 13'd2, 32'h200, 8'd0);
        issue(3'b110, 2'd0, 13'd0, 32'h0, 8'd0);
        issue(3'b011, 2'd0, 13'd5, 32'h0, 8'd0);
        issue(3'b101, 2'd3, 13'd3, 32'h300, 8'd3);
        check("full_level", 32'(level_o), 32'h4);
        check("full_ready", 32'(cmd_ready_o), 32'h0);
        drain("batch", 2000);
        check("batch_done_count", 32'(done_cnt - d0), 32'h4);
        check("batch_err_count", 32'(err_cnt - e0), 32'h1);
        gnt_toggle = 1'b0;

        // abort mid-stream with two commands queued
        clear_models();
        d0 = done_cnt;
        base = wr1_cnt;
        expect_cmd(3'b001, 8, 32'h1000, 1, 32'h4000_0040);
        issue(3'b001, 2'd0, 13'd8, 32'h1000, 8'd1);
        tick(2);
        issue(3'b010, 2'd1, 13'd4, 32'h0, 8'd1);
        issue(3'b111, 2'd2, 13'd4, 32'h0, 8'd1);
        check("abort_queued_level", 32'(level_o), 32'h2);
        w = 0;
        while (wr1_cnt < base + 3 && w < 200) begin
            tick(1);
            w++;
        end
        check("abort_reached_stream", 32'(wr1_cnt >= base + 3), 32'h1);
        abort_i = 1'b1;
        tick(1);
        abort_i = 1'b0;
        exp_q.delete();
        check("abort_busy", 32'(busy_o), 32'h0);
        check("abort_level", 32'(level_o), 32'h0);
        check("abort_req", 32'(bus_req_o), 32'h0);
        quiet = 0;
        repeat (20) begin
            @(negedge clk_i);
            if (dma_read_0_o || dma_write_0_o || dma_read_1_o || dma_write_1_o || done_o) quiet++;
        end
        check("abort_quiet", 32'(quiet), 32'h0);
        check("abort_no_done", 32'(done_cnt - d0), 32'h0);
        tick(1);

        // reset mid-transfer, then a fresh command
        clear_models();
        base = wr1_cnt;
        expect_cmd(3'b001, 8, 32'h2000, 1, 32'h4000_0043);
        issue(3'b001, 2'd3, 13'd8, 32'h2000, 8'd1);
        w = 0;
        while (wr1_cnt < base + 2 && w < 200) begin
            tick(1);
            w++;
        end
        rst_ni = 1'b0;
        #1;
        check("mid_rst_ready", 32'(cmd_ready_o), 32'h1);
        check("mid_rst_ctl", {25'd0, bus_req_o, busy_o, done_o, err_o, level_o}, 32'h0);
        check("mid_rst_strobes",
              {28'd0, dma_read_0_o, dma_write_0_o, dma_read_1_o, dma_write_1_o}, 32'h0);
        check("mid_rst_addr1", dma_addr_1_o, 32'h0);
        exp_q.delete();
        tick(2);
        rst_ni = 1'b1;
        tick(1);
        clear_models();
        d0 = done_cnt;
        expect_cmd(3'b111, 2, 32'h40, 1, 32'h4000_0402);
        issue(3'b111, 2'd2, 13'd2, 32'h40, 8'd1);
        drain("post_reset", 200);
        check("post_reset_done_count", 32'(done_cnt - d0), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
        $fatal(1, "watchdog expired");
    end

endmodule
